// File: rtl/sfx_sample_generator.sv
`timescale 1ns/1ps
// Four-voice sound-effect source (shot, explosion, invader step, UFO) mixed to a mono saturated sample on both Tx halves.
// Latency: Tx/busy update one Clock after the cycle in which Ready rises; stable otherwise. No backpressure, Ready paces frames.
module sfx_sample_generator #(
    parameter int WIDTH = 16,
    parameter int AMP   = 4096,
    parameter int PER0  = 4,
    parameter int DUR0  = 2000,
    parameter int DUR1  = 4096,
    parameter int PER2  = 40,
    parameter int DUR2  = 1500,
    parameter int PER3  = 12
) (
    input  logic               Clock,
    input  logic               nReset,
    input  logic               onOff,
    input  logic [3:0]         trig,
    input  logic               Ready,
    output logic [2*WIDTH-1:0] Tx,
    output logic [3:0]         busy
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] PLAY = 1'b1;

    localparam int CW = 16;
    localparam int EW = $clog2(DUR1);
    localparam int MW = WIDTH + 2;

    localparam logic signed [WIDTH-1:0] AMP_P = WIDTH'(AMP);
    localparam logic signed [WIDTH-1:0] AMP_N = -AMP_P;
    localparam logic signed [WIDTH-1:0] MAXW  = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] MINW  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic signed [MW-1:0]    SMAX  = {3'b000, {(WIDTH-1){1'b1}}};
    localparam logic signed [MW-1:0]    SMIN  = {3'b111, {(WIDTH-1){1'b0}}};

    logic                    ready_q, tick, upd;
    logic [3:0]              trig_m, trig_s;
    logic [2:0]              trig_p, rise, pend;
    logic [15:0]             lfsr;
    logic [3:0]              play;
    logic signed [WIDTH-1:0] voice [4];
    logic signed [MW-1:0]    sum;
    logic signed [WIDTH-1:0] mono;

    assign tick = Ready & ~ready_q;
    assign rise = trig_s[2:0] & ~trig_p;

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            ready_q <= 1'b0;
            upd     <= 1'b0;
            trig_m  <= '0;
            trig_s  <= '0;
            trig_p  <= '0;
            lfsr    <= 16'hACE1;
        end else begin
            ready_q <= Ready;
            upd     <= tick;
            trig_m  <= trig;
            trig_s  <= trig_m;
            trig_p  <= trig_s[2:0];
            if (tick)
                lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
        end
    end

    // An edge coinciding with a tick is kept for the following tick.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset)
            pend <= '0;
        else if (!onOff)
            pend <= '0;
        else if (tick)
            pend <= rise;
        else
            pend <= pend | rise;
    end

    // Square voices: 0 = shot, 2 = invader step.
    for (genvar g = 0; g < 2; g++) begin : g_sq
        localparam int N   = 2 * g;
        localparam int PER = (g == 0) ? PER0 : PER2;
        localparam int DUR = (g == 0) ? DUR0 : DUR2;

        logic [0:0]    st;
        logic [CW-1:0] ph, rem;
        logic          pol;

        always_ff @(posedge Clock or negedge nReset) begin
            if (!nReset) begin
                st  <= IDLE;
                ph  <= '0;
                rem <= '0;
                pol <= 1'b1;
            end else if (!onOff) begin
                st <= IDLE;
            end else if (tick) begin
                if (pend[N]) begin
                    st  <= PLAY;
                    ph  <= '0;
                    pol <= 1'b1;
                    rem <= CW'(DUR - 1);
                end else if (st == PLAY) begin
                    if (ph == CW'(PER - 1)) begin
                        ph  <= '0;
                        pol <= ~pol;
                    end else begin
                        ph <= ph + 1'b1;
                    end
                    if (rem == '0)
                        st <= IDLE;
                    else
                        rem <= rem - 1'b1;
                end
            end
        end

        assign play[N]  = (st == PLAY);
        assign voice[N] = (st == IDLE) ? '0 : (pol ? AMP_P : AMP_N);
    end

    // Explosion: LFSR-signed noise whose amplitude halves every quarter of its length.
    logic [0:0]              st1;
    logic [CW-1:0]           rem1;
    logic [EW-1:0]           elapsed;
    logic [1:0]              shift1;
    logic signed [WIDTH-1:0] mag1;

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            st1     <= IDLE;
            rem1    <= '0;
            elapsed <= '0;
        end else if (!onOff) begin
            st1 <= IDLE;
        end else if (tick) begin
            if (pend[1]) begin
                st1     <= PLAY;
                rem1    <= CW'(DUR1 - 1);
                elapsed <= '0;
            end else if (st1 == PLAY) begin
                elapsed <= elapsed + 1'b1;
                if (rem1 == '0)
                    st1 <= IDLE;
                else
                    rem1 <= rem1 - 1'b1;
            end
        end
    end

    assign shift1   = elapsed[EW-1 -: 2];
    assign mag1     = AMP_P >>> shift1;
    assign play[1]  = (st1 == PLAY);
    assign voice[1] = (st1 == IDLE) ? '0 : (lfsr[0] ? mag1 : -mag1);

    // UFO follows the synchronised trigger level, no duration limit.
    logic [0:0]    st3;
    logic [CW-1:0] ph3;
    logic          pol3;

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            st3  <= IDLE;
            ph3  <= '0;
            pol3 <= 1'b1;
        end else if (!onOff) begin
            st3 <= IDLE;
        end else if (tick) begin
            if (st3 == PLAY) begin
                if (!trig_s[3]) begin
                    st3 <= IDLE;
                end else if (ph3 == CW'(PER3 - 1)) begin
                    ph3  <= '0;
                    pol3 <= ~pol3;
                end else begin
                    ph3 <= ph3 + 1'b1;
                end
            end else if (trig_s[3]) begin
                st3  <= PLAY;
                ph3  <= '0;
                pol3 <= 1'b1;
            end
        end
    end

    assign play[3]  = (st3 == PLAY);
    assign voice[3] = (st3 == IDLE) ? '0 : (pol3 ? AMP_P : AMP_N);

    always_comb begin
        sum = $signed({{2{voice[0][WIDTH-1]}}, voice[0]})
            + $signed({{2{voice[1][WIDTH-1]}}, voice[1]})
            + $signed({{2{voice[2][WIDTH-1]}}, voice[2]})
            + $signed({{2{voice[3][WIDTH-1]}}, voice[3]});
        if (sum > SMAX)
            mono = MAXW;
        else if (sum < SMIN)
            mono = MINW;
        else
            mono = sum[WIDTH-1:0];
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            Tx   <= '0;
            busy <= '0;
        end else if (!onOff) begin
            Tx   <= '0;
            busy <= '0;
        end else if (upd) begin
            Tx   <= {mono, mono};
            busy <= play;
        end
    end
endmodule

// File: doc/sfx_sample_generator.md
# sfx_sample_generator

Sound-effect sample source for the game audio path. It sits directly upstream of the I2S transmitter, clocked by the same serial bit clock. On every Ready pulse it synthesises one new stereo frame: four fixed voices (shot, explosion, invader step, UFO) mixed and saturated. It presents the frame on a stable Tx word that the transmitter samples at its next word boundary.

## Interface
- WIDTH, 16: bits per channel; Tx is 2*WIDTH.
- AMP, 4096: peak amplitude per voice, signed. Must satisfy 4*AMP ≤ 2^(WIDTH-1)-1 for a clean mix; saturation still applies.
- PER0, 4: shot square half-period, in samples.
- DUR0, 2000: shot length, in samples.
- DUR1, 4096: explosion length, in samples. Power of two, ≥ 16.
- PER2, 40: invader-step square half-period, in samples.
- DUR2, 1500: invader-step length, in samples.
- PER3, 12: UFO square half-period, in samples.

- Clock  in  1  serial bit clock (SCLK); all logic on rising edge.
- nReset  in  1  reset; asynchronous, active-low.
- onOff  in  1  audio enable; level.
- trig  in  4  effect triggers from the game clock domain; asynchronous; each passes through a 2-flop synchroniser.
- Ready  in  1  word-taken pulse from the transmitter (high for ≥ 1 Clock).
- Tx  out  2*WIDTH  {left, right} signed samples; left in the upper half.
- busy  out  4  voice n is in PLAY.

## Operation
- Sample tick: ready_q <= Ready; tick = Ready & ~ready_q. There is exactly one tick per Ready rising edge.
- Trigger capture:
  - trig_s = synchronised trig; trig_p = trig_s delayed one cycle.
  - For voices 0–2, a rising edge (trig_s & ~trig_p) sets pend[n].
  - pend[n] is consumed and cleared at the next tick.
  - Edges arriving between ticks collapse into one event.
- Voice FSM (per voice), states IDLE and PLAY, evaluated only on tick:
  - IDLE → PLAY when pend[n]. Loads phase=0, pol=1, remaining=DURn-1; for voice 1, elapsed=0.
  - PLAY, pend[n] set: retrigger. Same loads as IDLE entry; stay in PLAY.
  - PLAY, otherwise:
    - phase advances; when phase==PERn-1, phase wraps to 0 and pol toggles.
    - remaining decrements; when remaining==0, go to IDLE.
  - Voice 3 (UFO) is level-driven, not edge-driven:
    - IDLE → PLAY on a tick with trig_s[3]=1.
    - PLAY → IDLE on a tick with trig_s[3]=0.
    - No duration counter.
- Voice outputs, signed WIDTH bits:
  - IDLE: 0.
  - Square voices: pol ? +AMP : -AMP.
  - Voice 1: lfsr[0] ? +(AMP>>s) : -(AMP>>s), where s = elapsed[log2(DUR1)-1 : log2(DUR1)-2]. This gives four decay steps, shift 0..3.
- LFSR: 16-bit Galois, taps 16'hB400, reset seed 16'hACE1; advances on every tick regardless of voice state.
- Mix:
  - Sign-extend all four voices to WIDTH+2 and sum.
  - Saturate to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - Result is mono and is driven on both halves of Tx.
- onOff=0:
  - All voices forced to IDLE; pend cleared; Tx <= 0 at the next Clock.
  - Triggers are ignored while low.
  - The LFSR keeps running.

## Timing
- Reset values: Tx=0, busy=0, all voices IDLE, pend=0, lfsr=16'hACE1, ready_q=0.
- Latency: Tx updates on the Clock edge one cycle after the tick cycle; it is stable otherwise. With a 32-cycle frame, Tx is settled ≥ 30 Clocks before the transmitter samples it.
- busy reflects the FSM state registered on the same edge as Tx.
- Trigger latency: 2 sync + 1 edge cycle to pend, then the next tick. The first nonzero sample appears within one frame plus 4 Clocks.
- A Ready held high for multiple cycles produces a single tick.
- Simultaneous pend and remaining==0 on the same tick: retrigger wins; voice stays in PLAY.
- Simultaneous trigger edge and tick in the same cycle: pend is set this cycle and consumed at the following tick.
- nReset asserted mid-frame: everything returns to reset values immediately (asynchronous). The first tick after release produces silence unless a trigger is pending.

## Test plan
- Reset then 10 Ready pulses, no triggers → Tx=32'h0 throughout; busy=4'b0000.
- Pulse trig[0], then 12 ticks → samples +4096 ×4, -4096 ×4, +4096 ×4; Tx halves equal. busy[0] falls exactly DUR0=2000 ticks after start.
- trig[0] and trig[2] together → mix 0x2000, 0x0000, or 0xE000 per the pol combination. Retrigger trig[0] at tick 1999 → busy[0] stays high for another 2000 ticks.
- trig[1] → magnitude 4096 for ticks 0–1023, 2048 for 1024–2047, 1024 next, then 512. Sign follows the LFSR from seed ACE1. Idle after 4096 ticks.
- trig[3] held for 100 ticks then released → UFO square with 12-tick half-period; busy[3] drops at the first tick after sync of the low level.
- Two tests:
  - With AMP=16383, all four voices positive → Tx halves saturate at 16'h7FFF, not wrap.
  - Then onOff=0 mid-play → Tx=0 next Clock, busy=0.
